// File: rtl/pixel_normalizer_stream.sv
`default_nettype none
// ============================================================================
// Module      : pixel_normalizer_stream
// Description : Streaming per-channel pixel normalizer placed between the
//               pixel source and the first CNN layer. For C interleaved
//               channels it computes
//                 pixel_out = sat(round((pixel - mean[ch]) * scale[ch] / 2^FRAC))
//               through a 3-stage valid/ready pipeline with backpressure.
//               The mean and scale coefficients are programmable at runtime.
//               A sticky flag reports channel misalignment.
// Ports       : clk, rst               clock, async active-high reset
//               in_valid/in_ready      input handshake
//               in_first, pixel_in     channel-0 marker, unsigned pixel
//               cfg_we/sel/ch/data     coefficient write port (sel 0=mean, 1=scale)
//               out_valid/out_ready    output handshake
//               pixel_out, out_ch      signed result and its channel tag
//               out_sat                result was clipped
//               align_err              sticky in_first-while-mid-group flag
// Revision    : 1.0  initial release
// ============================================================================
module pixel_normalizer_stream #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 16,
    parameter int COEF_W = 16,
    parameter int FRAC   = 8,
    parameter int C      = 3,
    localparam int CH_W  = (C > 1) ? $clog2(C) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_first,
    input  logic [IN_W-1:0]          pixel_in,
    input  logic                     cfg_we,
    input  logic                     cfg_sel,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [COEF_W-1:0]        cfg_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  pixel_out,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_sat,
    output logic                     align_err
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int DIFF_W = IN_W + 1;
    localparam int PROD_W = IN_W + 1 + COEF_W;
    // One guard bit so adding the rounding constant can never wrap.
    localparam int SUM_W  = PROD_W + 1;
    // Compare width covers both the rounded value and the output range.
    localparam int CMP_W  = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;

    localparam logic [CH_W-1:0]          C_CH_LAST   = CH_W'(C - 1);
    localparam logic [COEF_W-1:0]        C_SCALE_ONE = COEF_W'(64'd1 << FRAC);
    localparam logic signed [SUM_W-1:0]  C_HALF      = SUM_W'(64'sd1 <<< (FRAC - 1));
    localparam logic signed [CMP_W-1:0]  C_OUT_MAX   = CMP_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [CMP_W-1:0]  C_OUT_MIN   = CMP_W'(-(64'sd1 <<< (OUT_W - 1)));
    localparam logic [OUT_W-1:0]         C_PIX_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]         C_PIX_MIN   = {1'b1, {(OUT_W-1){1'b0}}};

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    logic [C-1:0][IN_W-1:0]    r_mean,      w_mean_d;
    logic [C-1:0][COEF_W-1:0]  r_scale,     w_scale_d;

    logic [CH_W-1:0]           r_ch_cnt,    w_ch_cnt_d;
    logic                      r_align_err, w_align_err_d;

    // S1: difference, channel and the scale captured with this pixel
    logic                      r_s1_valid,  w_s1_valid_d;
    logic signed [DIFF_W-1:0]  r_s1_diff,   w_s1_diff_d;
    logic [CH_W-1:0]           r_s1_ch,     w_s1_ch_d;
    logic [COEF_W-1:0]         r_s1_scale,  w_s1_scale_d;

    // S2: full-precision product
    logic                      r_s2_valid,  w_s2_valid_d;
    logic signed [PROD_W-1:0]  r_s2_prod,   w_s2_prod_d;
    logic [CH_W-1:0]           r_s2_ch,     w_s2_ch_d;

    // S3: rounded/saturated output register
    logic                      r_out_valid, w_out_valid_d;
    logic [OUT_W-1:0]          r_pixel_out, w_pixel_out_d;
    logic [CH_W-1:0]           r_out_ch,    w_out_ch_d;
    logic                      r_out_sat,   w_out_sat_d;

    // ------------------------------------------------------------------------
    // Handshake and channel tracking
    // ------------------------------------------------------------------------
    logic                      w_adv;
    logic                      w_xfer;
    logic [CH_W-1:0]           w_ch_in;
    logic [CH_W-1:0]           w_ch_next;

    // The whole pipeline moves as one; a stalled output freezes every stage,
    // including bubbles, which keeps the control trivially consistent.
    assign w_adv    = ~r_out_valid | out_ready;
    assign in_ready = w_adv;
    assign w_xfer   = in_valid & w_adv;

    // in_first forces channel 0 so a misaligned source resynchronises itself.
    assign w_ch_in   = in_first ? '0 : r_ch_cnt;
    assign w_ch_next = (w_ch_in == C_CH_LAST) ? '0 : w_ch_in + 1'b1;

    // ------------------------------------------------------------------------
    // Datapath arithmetic
    // ------------------------------------------------------------------------
    logic signed [PROD_W-1:0]  w_diff_ext;
    logic signed [PROD_W-1:0]  w_scale_ext;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [SUM_W-1:0]   w_prod_ext;
    logic signed [SUM_W-1:0]   w_sum;
    logic signed [SUM_W-1:0]   w_round;
    logic signed [CMP_W-1:0]   w_round_ext;

    // Both operands sign-extended to the product width so the truncated
    // product is exact.
    assign w_diff_ext  = {{COEF_W{r_s1_diff[DIFF_W-1]}}, r_s1_diff};
    assign w_scale_ext = {{DIFF_W{r_s1_scale[COEF_W-1]}}, r_s1_scale};
    assign w_prod      = w_diff_ext * w_scale_ext;

    // Adding half an LSB then shifting arithmetically rounds half toward +inf.
    assign w_prod_ext  = {r_s2_prod[PROD_W-1], r_s2_prod};
    assign w_sum       = w_prod_ext + C_HALF;
    assign w_round     = w_sum >>> FRAC;
    assign w_round_ext = {{(CMP_W-SUM_W){w_round[SUM_W-1]}}, w_round};

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_mean_d      = r_mean;
        w_scale_d     = r_scale;
        w_ch_cnt_d    = r_ch_cnt;
        w_align_err_d = r_align_err;

        w_s1_valid_d  = r_s1_valid;
        w_s1_diff_d   = r_s1_diff;
        w_s1_ch_d     = r_s1_ch;
        w_s1_scale_d  = r_s1_scale;

        w_s2_valid_d  = r_s2_valid;
        w_s2_prod_d   = r_s2_prod;
        w_s2_ch_d     = r_s2_ch;

        w_out_valid_d = r_out_valid;
        w_pixel_out_d = r_pixel_out;
        w_out_ch_d    = r_out_ch;
        w_out_sat_d   = r_out_sat;

        // Coefficient writes land at the edge, independent of stall state;
        // channel numbers >= C match no entry and are ignored.
        if (cfg_we) begin
            for (int i = 0; i < C; i++) begin
                if (cfg_ch == CH_W'(i)) begin
                    if (cfg_sel) begin
                        w_scale_d[i] = cfg_data;
                    end else begin
                        w_mean_d[i]  = cfg_data[IN_W-1:0];
                    end
                end
            end
        end

        if (w_xfer) begin
            w_ch_cnt_d = w_ch_next;
            if (in_first && (r_ch_cnt != '0)) begin
                w_align_err_d = 1'b1;
            end
        end

        if (w_adv) begin
            // S1: read coefficients from the registered copy, so a write in
            // the same cycle only affects later pixels.
            w_s1_valid_d = w_xfer;
            if (w_xfer) begin
                w_s1_diff_d  = $signed({1'b0, pixel_in}) - $signed({1'b0, r_mean[w_ch_in]});
                w_s1_ch_d    = w_ch_in;
                w_s1_scale_d = r_scale[w_ch_in];
            end

            // S2
            w_s2_valid_d = r_s1_valid;
            if (r_s1_valid) begin
                w_s2_prod_d = w_prod;
                w_s2_ch_d   = r_s1_ch;
            end

            // S3
            w_out_valid_d = r_s2_valid;
            if (r_s2_valid) begin
                w_out_ch_d = r_s2_ch;
                if (w_round_ext > C_OUT_MAX) begin
                    w_pixel_out_d = C_PIX_MAX;
                    w_out_sat_d   = 1'b1;
                end else if (w_round_ext < C_OUT_MIN) begin
                    w_pixel_out_d = C_PIX_MIN;
                    w_out_sat_d   = 1'b1;
                end else begin
                    w_pixel_out_d = w_round_ext[OUT_W-1:0];
                    w_out_sat_d   = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < C; i++) begin
                r_mean[i]  <= '0;
                r_scale[i] <= C_SCALE_ONE;
            end
            r_ch_cnt    <= '0;
            r_align_err <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_diff   <= '0;
            r_s1_ch     <= '0;
            r_s1_scale  <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_prod   <= '0;
            r_s2_ch     <= '0;
            r_out_valid <= 1'b0;
            r_pixel_out <= '0;
            r_out_ch    <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_mean      <= w_mean_d;
            r_scale     <= w_scale_d;
            r_ch_cnt    <= w_ch_cnt_d;
            r_align_err <= w_align_err_d;
            r_s1_valid  <= w_s1_valid_d;
            r_s1_diff   <= w_s1_diff_d;
            r_s1_ch     <= w_s1_ch_d;
            r_s1_scale  <= w_s1_scale_d;
            r_s2_valid  <= w_s2_valid_d;
            r_s2_prod   <= w_s2_prod_d;
            r_s2_ch     <= w_s2_ch_d;
            r_out_valid <= w_out_valid_d;
            r_pixel_out <= w_pixel_out_d;
            r_out_ch    <= w_out_ch_d;
            r_out_sat   <= w_out_sat_d;
        end
    end

    assign out_valid = r_out_valid;
    assign pixel_out = r_pixel_out;
    assign out_ch    = r_out_ch;
    assign out_sat   = r_out_sat;
    assign align_err = r_align_err;

endmodule
`default_nettype wire

// File: tb/tb_pixel_normalizer_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_normalizer_stream
// Description : Directed self-checking bench for pixel_normalizer_stream.
//               Instance A uses default widths, instance B uses OUT_W=12.
//               Both instances share every input. Expected results are
//               hand-computed constants.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pixel_normalizer_stream;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_first = 1'b0;
    logic [7:0]         pixel_in = '0;
    logic               cfg_we = 1'b0;
    logic               cfg_sel = 1'b0;
    logic [1:0]         cfg_ch = '0;
    logic [15:0]        cfg_data = '0;
    logic               out_ready = 1'b1;
    logic               rand_en = 1'b0;

    logic               in_ready_a, out_valid_a, out_sat_a, align_err_a;
    logic signed [15:0] pixel_out_a;
    logic [1:0]         out_ch_a;
    logic               in_ready_b, out_valid_b, out_sat_b, align_err_b;
    logic signed [11:0] pixel_out_b;
    logic [1:0]         out_ch_b;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic signed [31:0] pix;
        logic signed [31:0] ch;
        logic signed [31:0] sat;
    } res_t;

    res_t qa[$];
    res_t qb[$];

    always #5 clk = ~clk;

    pixel_normalizer_stream dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_first(in_first), .pixel_in(pixel_in), .cfg_we(cfg_we),
        .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_data(cfg_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .pixel_out(pixel_out_a),
        .out_ch(out_ch_a), .out_sat(out_sat_a), .align_err(align_err_a)
    );

    pixel_normalizer_stream #(.OUT_W(12)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_first(in_first), .pixel_in(pixel_in), .cfg_we(cfg_we),
        .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_data(cfg_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .pixel_out(pixel_out_b),
        .out_ch(out_ch_b), .out_sat(out_sat_b), .align_err(align_err_b)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // out_ready is owned here: random while rand_en, otherwise always 1.
    always @(negedge clk) begin
        #1;
        out_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: collects accepted results and checks that a stalled
    // output holds steady until it is taken.
    logic               stall_prev = 1'b0;
    logic signed [15:0] prev_pix   = '0;
    logic [1:0]         prev_ch    = '0;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            chk("in_ready_b", in_ready_b, in_ready_a);
            if (stall_prev) begin
                chk("hold_valid", out_valid_a, 1);
                chk("hold_pix", pixel_out_a, prev_pix);
                chk("hold_ch", out_ch_a, prev_ch);
            end
            if (out_valid_a && out_ready) qa.push_back('{pixel_out_a, out_ch_a, out_sat_a});
            if (out_valid_b && out_ready) qb.push_back('{pixel_out_b, out_ch_b, out_sat_b});
            stall_prev = out_valid_a && !out_ready;
            prev_pix   = pixel_out_a;
            prev_ch    = out_ch_a;
        end
    end

    // Present one pixel and hold it until it has been accepted.
    task automatic send(input logic [7:0] pix, input logic first);
        int guard;
        in_valid = 1'b1;
        pixel_in = pix;
        in_first = first;
        #1;
        guard = 0;
        while (!in_ready_a && guard < 200) begin
            @(negedge clk); #2;
            guard++;
        end
        if (guard >= 200) chk("send_timeout", guard, 0);
        @(negedge clk); #1;
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic cfg_write(input logic sel, input logic [1:0] ch, input logic [15:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_ch   = ch;
        cfg_data = data;
        @(negedge clk); #1;
        cfg_we   = 1'b0;
    endtask

    task automatic wait_q(input int n);
        int cyc;
        cyc = 0;
        while (qa.size() < n && cyc < 300) begin
            @(negedge clk); #3;
            cyc++;
        end
        chk("queue_len", qa.size(), n);
    endtask

    task automatic chk_a(input int idx, input int pix, input int ch, input int sat);
        if (idx < qa.size()) begin
            chk("a_pix", qa[idx].pix, pix);
            chk("a_ch",  qa[idx].ch,  ch);
            chk("a_sat", qa[idx].sat, sat);
        end else begin
            chk("a_missing", idx, -1);
        end
    endtask

    task automatic chk_b(input int idx, input int pix, input int ch, input int sat);
        if (idx < qb.size()) begin
            chk("b_pix", qb[idx].pix, pix);
            chk("b_ch",  qb[idx].ch,  ch);
            chk("b_sat", qb[idx].sat, sat);
        end else begin
            chk("b_missing", idx, -1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        #1 rst = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_in_ready", in_ready_a, 1);
        chk("rst_pixel_out", pixel_out_a, 0);
        chk("rst_out_ch", out_ch_a, 0);
        chk("rst_out_sat", out_sat_a, 0);
        chk("rst_align_err", align_err_a, 0);
        rst = 1'b0;
        @(negedge clk); #1;

        // ---------------- T1: defaults and 3-cycle latency ----------------
        send(8'd200, 1'b1);
        #1 chk("t1_lat1", out_valid_a, 0);
        @(negedge clk); #2 chk("t1_lat2", out_valid_a, 0);
        @(negedge clk); #2 chk("t1_lat3", out_valid_a, 1);
        chk("t1_pix", pixel_out_a, 200);
        chk("t1_ch", out_ch_a, 0);
        chk("t1_sat", out_sat_a, 0);
        send(8'd0, 1'b0);
        send(8'd0, 1'b0);
        wait_q(3);
        chk_a(0, 200, 0, 0);
        chk_a(1, 0, 1, 0);
        chk_a(2, 0, 2, 0);
        qa.delete(); qb.delete();

        // ---------------- T2: ch1 mean 128, scale 2.0 ----------------
        cfg_write(1'b0, 2'd1, 16'd128);
        cfg_write(1'b1, 2'd1, 16'h0200);
        send(8'd0, 1'b1);
        send(8'd200, 1'b0);
        send(8'd0, 1'b0);
        wait_q(3);
        chk_a(0, 0, 0, 0);
        chk_a(1, 144, 1, 0);
        chk_a(2, 0, 2, 0);
        qa.delete(); qb.delete();

        // ---------------- T3: rounding, mean 100, scale 0.5 ----------------
        for (int c = 0; c < 3; c++) begin
            cfg_write(1'b0, 2'(c), 16'd100);
            cfg_write(1'b1, 2'(c), 16'h0080);
        end
        // First pixel shares its cycle with a mean write: it sees mean=100.
        in_valid = 1'b1; pixel_in = 8'd101; in_first = 1'b1;
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_ch = 2'd0; cfg_data = 16'd0;
        @(negedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0; cfg_we = 1'b0;
        send(8'd99, 1'b0);
        send(8'd97, 1'b0);
        send(8'd101, 1'b1);
        send(8'd99, 1'b0);
        send(8'd97, 1'b0);
        wait_q(6);
        chk_a(0, 1, 0, 0);
        chk_a(1, 0, 1, 0);
        chk_a(2, -1, 2, 0);
        chk_a(3, 51, 0, 0);
        chk_a(4, 0, 1, 0);
        chk_a(5, -1, 2, 0);
        qa.delete(); qb.delete();

        // ---------------- T4: saturation (B has OUT_W=12) ----------------
        cfg_write(1'b1, 2'd0, 16'h7FFF);
        cfg_write(1'b0, 2'd1, 16'd255);
        cfg_write(1'b1, 2'd1, 16'h7FFF);
        send(8'd255, 1'b1);
        send(8'd0, 1'b0);
        send(8'd0, 1'b0);
        wait_q(3);
        chk_a(0, 32639, 0, 0);
        chk_a(1, -32639, 1, 0);
        chk_a(2, -50, 2, 0);
        chk_b(0, 2047, 0, 1);
        chk_b(1, -2048, 1, 1);
        chk_b(2, -50, 2, 0);
        qa.delete(); qb.delete();

        // ---------------- T5: backpressure, identity coefficients ----------------
        cfg_write(1'b1, 2'd0, 16'h0100);
        cfg_write(1'b0, 2'd1, 16'd0);
        cfg_write(1'b1, 2'd1, 16'h0100);
        cfg_write(1'b0, 2'd2, 16'd0);
        cfg_write(1'b1, 2'd2, 16'h0100);
        rand_en = 1'b1;
        for (int i = 0; i < 9; i++) send(8'(10 * (i + 1)), (i % 3) == 0);
        wait_q(9);
        rand_en = 1'b0;
        for (int i = 0; i < 9; i++) chk_a(i, 10 * (i + 1), i % 3, 0);
        chk("t5_align", align_err_a, 0);
        qa.delete(); qb.delete();

        // ---------------- T6: misalignment and mid-burst reset ----------------
        @(negedge clk); #1;
        send(8'd40, 1'b1);
        send(8'd50, 1'b1);
        send(8'd60, 1'b0);
        wait_q(3);
        chk("t6_align", align_err_a, 1);
        chk_a(0, 40, 0, 0);
        chk_a(1, 50, 0, 0);
        chk_a(2, 60, 1, 0);
        qa.delete(); qb.delete();

        cfg_write(1'b0, 2'd0, 16'd50);
        send(8'd100, 1'b0);
        send(8'd100, 1'b1);
        send(8'd100, 1'b0);
        chk("t6_pre_rst_valid", out_valid_a, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid_a, 0);
        chk("t6_rst_align", align_err_a, 0);
        chk("t6_rst_pix", pixel_out_a, 0);
        @(negedge clk); @(negedge clk); #1;
        rst = 1'b0;
        qa.delete(); qb.delete();
        @(negedge clk); #1;
        // Default mean 0 / scale 1.0 must be back on ch0.
        send(8'd200, 1'b1);
        wait_q(1);
        chk_a(0, 200, 0, 0);
        repeat (5) @(negedge clk);
        #3 chk("t6_no_extra", qa.size(), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
